// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int COLS  = 4;
    localparam int ROWS  = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    // Key code of a matrix position: row-major numbering.
    function automatic logic [KEY_W-1:0] key_code_of(input logic [1:0] r, input logic [1:0] c);
        return KEY_W'(int'(r) * COLS + int'(c));
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the key-event outputs.
// master: the scanner side; slave: the keypad / consumer side.
interface keypad_scanner_if;

    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output col,
        output key_code,
        output key_valid,
        output key_held,
        input  row
    );

    modport slave (
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held,
        output row
    );

endinterface

// File: rtl/keypad_scanner_tick.sv
// Prescaler producing a one-cycle scan tick every SCAN_DIV clocks.
module keypad_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt_p0;

    // Tick fires on the wrap cycle of the counter.
    always_comb tick = (cnt_p0 == CW'(SCAN_DIV - 1));

    // Free-running 0..SCAN_DIV-1 counter.
    always_ff @(posedge clk) begin
        if (rst)       cnt_p0 <= '0;
        else if (tick) cnt_p0 <= '0;
        else           cnt_p0 <= cnt_p0 + 1'b1;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: active-low column drive, synchronized row sense,
// debounced press/release, one-cycle key_valid strobe and key_held level.
// Optional auto-repeat of key_valid while held: define KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 200,
    parameter int REPEAT_RATE    = 50
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kif
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic             tick;
    logic [ROWS-1:0]  row_p0, row_p1;
    state_t           state_q, state_n;
    logic [1:0]       col_idx_q, col_idx_n;
    logic [1:0]       cand_row_q, cand_row_n;
    logic [1:0]       cand_col_q, cand_col_n;
    logic [CNT_W-1:0] deb_q, deb_n, deb_inc;
    logic [CNT_W-1:0] rel_q, rel_n, rel_inc;
    logic [KEY_W-1:0] code_q, code_n;
    logic             valid_q, valid_n;
    logic             held_q, held_n;
    logic             accept;
    logic [1:0]       acc_row, acc_col;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    logic [REP_W-1:0] rep_q, rep_n;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY != REPEAT_RATE);
`endif

    // Lowest-index low row wins when several rows are pressed.
    function automatic logic [1:0] lowest_low(input logic [ROWS-1:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer for the asynchronous row lines; row_p1 is row_s.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_p0 <= '1;
            row_p1 <= '1;
        end else begin
            row_p0 <= kif.row;
            row_p1 <= row_p0;
        end
    end

    assign deb_inc = deb_q + CNT_W'(1);
    assign rel_inc = rel_q + CNT_W'(1);

    // Next-state and output decode; everything moves only on scan ticks.
    always_comb begin
        state_n    = state_q;
        col_idx_n  = col_idx_q;
        cand_row_n = cand_row_q;
        cand_col_n = cand_col_q;
        deb_n      = deb_q;
        rel_n      = rel_q;
        code_n     = code_q;
        valid_n    = 1'b0;
        held_n     = held_q;
        accept     = 1'b0;
        acc_row    = cand_row_q;
        acc_col    = cand_col_q;
`ifdef KEYPAD_REPEAT_EN
        rep_n      = rep_q;
`endif
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (row_p1 != '1) begin
                        cand_row_n = lowest_low(row_p1);
                        cand_col_n = col_idx_q;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept  = 1'b1;
                            acc_row = lowest_low(row_p1);
                            acc_col = col_idx_q;
                        end else begin
                            deb_n   = CNT_W'(1);
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        col_idx_n = col_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!row_p1[cand_row_q]) begin
                        if (deb_inc == CNT_W'(DEBOUNCE_SCANS)) accept = 1'b1;
                        else                                   deb_n  = deb_inc;
                    end else begin
                        state_n   = SCAN;
                        deb_n     = '0;
                        col_idx_n = col_idx_q + 2'd1;
                    end
                end
                PRESSED: begin
                    if (row_p1[cand_row_q] && (rel_inc == CNT_W'(DEBOUNCE_SCANS))) begin
                        state_n   = SCAN;
                        held_n    = 1'b0;
                        rel_n     = '0;
                        col_idx_n = col_idx_q + 2'd1;
`ifdef KEYPAD_REPEAT_EN
                        rep_n     = '0;
`endif
                    end else begin
                        rel_n = row_p1[cand_row_q] ? rel_inc : '0;
`ifdef KEYPAD_REPEAT_EN
                        if (rep_q == REP_W'(1)) begin
                            valid_n = 1'b1;
                            rep_n   = REP_W'(REPEAT_RATE);
                        end else begin
                            rep_n   = rep_q - REP_W'(1);
                        end
`endif
                    end
                end
                default: state_n = SCAN;
            endcase
        end
        if (accept) begin
            state_n = PRESSED;
            code_n  = key_code_of(acc_row, acc_col);
            valid_n = 1'b1;
            held_n  = 1'b1;
            deb_n   = '0;
            rel_n   = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_n   = REP_W'(REPEAT_DELAY);
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            col_idx_q  <= '0;
            cand_row_q <= '0;
            cand_col_q <= '0;
            deb_q      <= '0;
            rel_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q      <= '0;
`endif
        end else begin
            state_q    <= state_n;
            col_idx_q  <= col_idx_n;
            cand_row_q <= cand_row_n;
            cand_col_q <= cand_col_n;
            deb_q      <= deb_n;
            rel_q      <= rel_n;
            code_q     <= code_n;
            valid_q    <= valid_n;
            held_q     <= held_n;
`ifdef KEYPAD_REPEAT_EN
            rep_q      <= rep_n;
`endif
        end
    end

    assign kif.col       = ~(4'b0001 << col_idx_q);
    assign kif.key_code  = code_q;
    assign kif.key_valid = valid_q;
    assign kif.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a tick-level keypad model.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DS = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = 16'h0000;

    int tests = 0;
    int fails = 0;
    int strobes = 0;

    // Reference model state (per scan tick)
    int m_phase;   // 0 idle, 1 confirming, 2 held
    int m_col, m_crow, m_ccol, m_streak, m_rel, m_code, m_since;
    bit m_valid, m_held;

    always #5 clk = ~clk;

    keypad_scanner_if kif();

    // Physical keypad: a pressed key shorts its row to its column.
    always_comb begin
        kif.row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kif.col[c]) kif.row[r] = 1'b0;
    end

    keypad_scanner #(
        .SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif.master)
    );

    task automatic model_reset();
        m_phase = 0; m_col = 0; m_crow = 0; m_ccol = 0; m_streak = 0;
        m_rel = 0; m_code = 0; m_since = 0; m_valid = 0; m_held = 0;
    endtask

    task automatic model_accept();
        m_phase = 2; m_code = m_crow * 4 + m_ccol;
        m_valid = 1; m_held = 1; m_rel = 0; m_since = 0;
    endtask

    task automatic model_tick();
        bit [3:0] low;
        m_valid = 0;
        for (int r = 0; r < 4; r++) low[r] = pressed[r*4+m_col];
        case (m_phase)
            0: begin
                if (low != 4'b0) begin
                    for (int r = 3; r >= 0; r--) if (low[r]) m_crow = r;
                    m_ccol = m_col;
                    m_streak = 1;
                    if (m_streak >= DS) model_accept(); else m_phase = 1;
                end else m_col = (m_col + 1) % 4;
            end
            1: begin
                if (low[m_crow]) begin
                    m_streak++;
                    if (m_streak == DS) model_accept();
                end else begin
                    m_phase = 0; m_col = (m_col + 1) % 4;
                end
            end
            default: begin
                if (!low[m_crow]) begin
                    m_rel++;
                    if (m_rel == DS) begin
                        m_phase = 0; m_held = 0; m_col = (m_col + 1) % 4;
                    end
                end else m_rel = 0;
`ifdef KEYPAD_REPEAT_EN
                if (m_phase == 2) begin
                    m_since++;
                    if (m_since == RD || (m_since > RD && (m_since - RD) % RR == 0)) m_valid = 1;
                end
`endif
            end
        endcase
    endtask

    // Advance one scan period; check quiet cycles and the tick cycle.
    task automatic step_tick();
        logic [3:0] ec;
        ec = ~(4'b0001 << m_col);
        for (int k = 0; k < SD - 1; k++) begin
            @(posedge clk); #1;
            tests++;
            if (kif.key_valid !== 1'b0 || kif.col !== ec) begin
                fails++;
                $display("FAIL quiet_cycle: valid=%b col=%b, required valid=0 col=%b", kif.key_valid, kif.col, ec);
            end
        end
        @(posedge clk); #1;
        model_tick();
        ec = ~(4'b0001 << m_col);
        tests++;
        if (kif.col !== ec || kif.key_valid !== m_valid || kif.key_code !== 4'(m_code) || kif.key_held !== m_held) begin
            fails++;
            $display("FAIL tick_outputs: col=%b valid=%b code=%0d held=%b, required col=%b valid=%b code=%0d held=%b",
                     kif.col, kif.key_valid, kif.key_code, kif.key_held, ec, m_valid, m_code, m_held);
        end
        if (kif.key_valid === 1'b1) strobes++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        tests++;
        if (kif.col !== 4'b1110 || kif.key_code !== 4'd0 || kif.key_valid !== 1'b0 || kif.key_held !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: col=%b code=%0d valid=%b held=%b, required 1110/0/0/0",
                     kif.col, kif.key_code, kif.key_valid, kif.key_held);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_val(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic wait_held(input bit level, input int budget, input string name);
        for (int i = 0; i < budget && m_held != level; i++) step_tick();
        check_val(name, int'(kif.key_held), int'(level));
    endtask

    task automatic test_reset();
        pressed = 16'h0;
        do_reset(2);
        for (int i = 0; i < 5; i++) step_tick();
        check_val("rotation_col", int'(kif.col), int'(4'b1101));
    endtask

    task automatic test_clean_press();
        pressed = 16'h0;
        strobes = 0;
        pressed[9] = 1'b1;
        wait_held(1'b1, 20, "press9_held");
        check_val("press9_code", int'(kif.key_code), 9);
        step_tick(); step_tick();
        pressed = 16'h0;
        step_tick(); step_tick();
        check_val("release_still_held", int'(kif.key_held), 1);
        step_tick();
        check_val("release_held_low", int'(kif.key_held), 0);
        check_val("resume_col2", int'(kif.col), int'(4'b1011));
        check_val("press9_strobes", strobes, 1);
    endtask

    task automatic test_bounce();
        pressed = 16'h0;
        strobes = 0;
        for (int i = 0; i < 4 && m_col != 0; i++) step_tick();
        pressed[0] = 1'b1;
        step_tick();
        pressed = 16'h0;
        step_tick();
        check_val("bounce_col_adv", int'(kif.col), int'(4'b1101));
        step_tick(); step_tick();
        check_val("bounce_strobes", strobes, 0);
    endtask

    task automatic test_two_rows();
        pressed = 16'h0;
        pressed[7] = 1'b1;
        pressed[15] = 1'b1;
        wait_held(1'b1, 20, "two_rows_held");
        check_val("two_rows_code", int'(kif.key_code), 7);
        pressed = 16'h0;
        wait_held(1'b0, 10, "two_rows_release");
    endtask

    task automatic test_reset_mid_press();
        pressed = 16'h0;
        pressed[15] = 1'b1;
        wait_held(1'b1, 20, "key15_held");
        do_reset(1);
        strobes = 0;
        wait_held(1'b1, 20, "key15_reheld");
        check_val("key15_code", int'(kif.key_code), 15);
        check_val("key15_restrobe", strobes, 1);
        pressed = 16'h0;
        wait_held(1'b0, 10, "key15_release");
    endtask

    task automatic test_repeat();
        pressed = 16'h0;
        pressed[6] = 1'b1;
        wait_held(1'b1, 20, "key6_held");
        strobes = 0;
        for (int i = 0; i < 12; i++) step_tick();
`ifdef KEYPAD_REPEAT_EN
        check_val("repeat_strobes", strobes, 4);
`else
        check_val("no_repeat_strobes", strobes, 0);
`endif
        check_val("key6_code", int'(kif.key_code), 6);
        pressed = 16'h0;
        wait_held(1'b0, 10, "key6_release");
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            pressed = 16'(1) << $urandom_range(15);
            if ($urandom_range(3) == 0) pressed = pressed | (16'(1) << $urandom_range(15));
            for (int t = 0; t < int'($urandom_range(8)); t++) step_tick();
            pressed = 16'h0;
            for (int t = 0; t < int'($urandom_range(6)); t++) step_tick();
        end
        pressed = 16'h0;
        wait_held(1'b0, 10, "random_idle");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_two_rows();
        test_reset_mid_press();
        test_repeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4×4 matrix keypad and turns debounced presses into 4-bit key codes. It drives one column low at a time, using the same active-low time-multiplexed scheme as the display commons, and reads the row lines back. Outputs are a one-cycle `key_valid` strobe with `key_code`, plus a `key_held` level. It sits next to the countdown/display logic as the user-entry path for preset values.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per column slot (scan tick period); minimum 2.
- `DEBOUNCE_SCANS`, default 4: consecutive matching samples needed to accept a press or a release; minimum 1.
- `REPEAT_DELAY`, default 200: ticks from accept to first repeat (used only with `KEYPAD_REPEAT_EN`).
- `REPEAT_RATE`, default 50: ticks between subsequent repeats (used only with `KEYPAD_REPEAT_EN`).
- `clk  input  1`: system clock.
- `rst  input  1`: synchronous reset, active-high.
- `col  output  4`: column drive, active-low, exactly one bit low at any time.
- `row  input  4`: row sense, active-low, externally pulled up, asynchronous to `clk`.
- `key_code  output  4`: code of the last accepted key, equal to row_index*4 + col_index.
- `key_valid  output  1`: one-cycle strobe when `key_code` is updated.
- `key_held  output  1`: high while an accepted key remains pressed.

## Operation
- Reset values:
  - Outputs: `col`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0.
  - Internal: state SCAN, tick counter 0, column index 0, debounce counter 0, both synchronizer stages 4'b1111.
- `row` passes through a 2-flop synchronizer. Only the synchronized value `row_s` is used.
- Tick counter counts 0..SCAN_DIV-1 and wraps. The tick fires on the wrap cycle. All sampling and state transitions happen only on tick cycles.
- `col` = ~(1 << col_idx). `col_idx` advances modulo 4 (3 wraps to 0) only on ticks in SCAN state, and only when no row is low.
- States:
  - SCAN: on tick, if any `row_s` bit is low, latch cand_row (the lowest-index low bit) and cand_col=`col_idx`. Set deb_cnt=1 and go to DEBOUNCE; the column freezes. If DEBOUNCE_SCANS=1, go straight to PRESSED with the strobe.
  - DEBOUNCE: on tick, if `row_s[cand_row]` is low, increment deb_cnt. When deb_cnt reaches DEBOUNCE_SCANS, load `key_code`, pulse `key_valid`, and go to PRESSED. If `row_s[cand_row]` is high, return to SCAN and advance the column on that tick.
  - PRESSED: `key_held`=1. On tick, `row_s[cand_row]` high increments rel_cnt; low clears rel_cnt. When rel_cnt reaches DEBOUNCE_SCANS, go to SCAN with `key_held`=0, advancing the column on that tick.
- Multiple rows low in the same column: the lowest row index wins. Presses in other columns are invisible while frozen; no rollover detection.
- Counters saturate by construction: each resets on its state exit, with width $clog2(param+1).
- `rst` mid-press: everything returns to reset values on the next edge. A key still held after reset is re-detected and re-strobed through normal debounce.

## Timing
- Row edge to `row_s`: 2 cycles.
- Press accept: `key_valid` asserts on the DEBOUNCE_SCANS-th consecutive matching tick, counting the detecting tick as the 1st. `key_code` is valid in that same cycle and stays stable until the next strobe.
- `key_held` rises in the cycle `key_valid` pulses. It falls on the tick that completes release debounce.
- Scan tick coincident with `rst`: reset wins.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In PRESSED, a repeat counter counts ticks.
  - At REPEAT_DELAY ticks after accept, and then every REPEAT_RATE ticks, `key_valid` pulses again with an unchanged `key_code`.
  - The repeat counter clears on exit from PRESSED.
- `KEYPAD_REPEAT_EN` not defined: exactly one `key_valid` per press. `REPEAT_*` are ignored and no repeat counter is synthesized.

## Structure
- Package `keypad_pkg` holds:
  - the state enum {SCAN, DEBOUNCE, PRESSED};
  - `KEY_W`=4;
  - `COLS`=4 and `ROWS`=4;
  - the function computing code = row*COLS + col.
- One sub-module, `keypad_tick`: parameterized prescaler producing the one-cycle scan tick from `clk`/`rst`.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3.
- Reset: assert `rst` 2 cycles with `row`=4'b1111 → `col`=4'b1110, outputs 0. `col` then rotates 1110→1101→1011→0111→1110, one step every 4 clks.
- Clean press: hold key (row 2, col 1), so `row`=4'b1011 whenever `col`=4'b1101 → exactly one `key_valid` with `key_code`=9 on the 3rd matching tick, and `key_held`=1. Release → `key_held`=0 after 3 high ticks, and scanning resumes from col 2.
- Bounce: key (0,0) low for 1 tick, then high → no `key_valid`, return to SCAN, column advances.
- Two rows: rows 1 and 3 low on col 3 → `key_code`=7 (row 1 wins).
- Reset mid-press: `rst` pulse while key (3,3) is held in PRESSED → outputs cleared, then re-strobe with `key_code`=15 after re-debounce.
- Repeat (`KEYPAD_REPEAT_EN`, REPEAT_DELAY=5, REPEAT_RATE=2): hold key 6 for 12 ticks past accept → strobes at accept +5, +7, +9, +11 ticks, all with code 6.
